// File: rtl/ppu_write_queue.sv
// ppu_write_queue: buffers CPU writes to PPU memories and releases them only during vblank.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   avs_chipselect      Avalon slave select
//   avs_write/avs_read  Avalon write / read strobes
//   avs_address         Avalon word address (CSR_ADDR selects the control/status register)
//   avs_writedata       Avalon write data
//   avs_readdata        registered CSR read data, valid the cycle after the read
//   avs_waitrequest     stalls a PPU-bound write while the queue is full
//   vblank              vertical blank level; queued writes drain only while high
//   ppu_chipselect      one-cycle pulse per drained entry
//   ppu_write           same as ppu_chipselect
//   ppu_address         address of the drained entry
//   ppu_write_data      data of the drained entry
//   irq                 frame interrupt level, held until cleared through the CSR
module ppu_write_queue #(
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] CSR_ADDR = 12'hFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              avs_chipselect,
    input  logic              avs_write,
    input  logic              avs_read,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    input  logic              vblank,
    output logic              ppu_chipselect,
    output logic              ppu_write,
    output logic [ADDR_W-1:0] ppu_address,
    output logic [DATA_W-1:0] ppu_write_data,
    output logic              irq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                   state, state_d;
    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;
    logic                     full, empty, is_csr, ppu_req, csr_wr, csr_rd;
    logic                     push, pop, last_pop, rise;
    logic                     vblank_q, irq_en, irq_pending, overflow;
    logic [7:0]               count8;
    logic [31:0]              status;

    assign full            = count == CW'(DEPTH);
    assign empty           = count == '0;
    assign is_csr          = avs_address == CSR_ADDR;
    assign ppu_req         = avs_chipselect & avs_write & ~is_csr;
    assign csr_wr          = avs_chipselect & avs_write & is_csr;
    assign csr_rd          = avs_chipselect & avs_read & is_csr;
    // A pop in the same cycle does not release a full queue early.
    assign avs_waitrequest = ppu_req & full;
    assign push            = ppu_req & ~full;
    assign pop             = (state == DRAIN) & vblank & ~empty;
    assign last_pop        = pop & ~push & (count == CW'(1));
    assign rise            = vblank & ~vblank_q;
    assign count8          = 8'(count);
    assign status          = {16'b0, count8, 4'b0, full, empty, irq_en, irq_pending};
    assign ppu_write       = ppu_chipselect;
    assign irq             = irq_pending;

    always_comb begin
        state_d = state;
        if (state == IDLE)
            state_d = (vblank && !empty) ? DRAIN : IDLE;
        else
            state_d = (vblank && !empty && !last_pop) ? DRAIN : IDLE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {avs_address, avs_writedata};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            vblank_q       <= 1'b0;
            irq_en         <= 1'b0;
            irq_pending    <= 1'b0;
            overflow       <= 1'b0;
            avs_readdata   <= '0;
            ppu_chipselect <= 1'b0;
            ppu_address    <= '0;
            ppu_write_data <= '0;
        end else begin
            state          <= state_d;
            wr_ptr         <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr         <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count          <= count + CW'(push) - CW'(pop);
            vblank_q       <= vblank;
            irq_en         <= csr_wr ? avs_writedata[1] : irq_en;
            // A rising edge beats a clear arriving in the same cycle.
            irq_pending    <= (rise & irq_en) ? 1'b1 : (csr_wr & avs_writedata[0]) ? 1'b0 : irq_pending;
            overflow       <= avs_waitrequest ? 1'b1 : (csr_wr & avs_writedata[2]) ? 1'b0 : overflow;
            avs_readdata   <= csr_rd ? DATA_W'(status) : '0;
            ppu_chipselect <= pop;
            {ppu_address, ppu_write_data} <= pop ? mem[rd_ptr] : '0;
        end
    end
endmodule

// File: tb/tb_ppu_write_queue.sv
// tb_ppu_write_queue: self-checking bench for ppu_write_queue.
module tb_ppu_write_queue;
    logic        clk = 0, reset = 1;
    logic        avs_chipselect = 0, avs_write = 0, avs_read = 0;
    logic [11:0] avs_address = 0;
    logic [31:0] avs_writedata = 0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        vblank = 0;
    logic        ppu_chipselect, ppu_write;
    logic [11:0] ppu_address;
    logic [31:0] ppu_write_data;
    logic        irq;
    int          checks = 0, failures = 0;
    logic [11:0] ga[$];
    logic [31:0] gd[$];

    ppu_write_queue dut (
        .clk(clk), .reset(reset),
        .avs_chipselect(avs_chipselect), .avs_write(avs_write), .avs_read(avs_read),
        .avs_address(avs_address), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .vblank(vblank),
        .ppu_chipselect(ppu_chipselect), .ppu_write(ppu_write),
        .ppu_address(ppu_address), .ppu_write_data(ppu_write_data),
        .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ppu_write) begin
        ga.push_back(ppu_address);
        gd.push_back(ppu_write_data);
    end

    typedef struct {
        bit          rd;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        avs_chipselect = 1; avs_write = 1; avs_address = a; avs_writedata = d;
        tick();
        avs_chipselect = 0; avs_write = 0;
    endtask

    task automatic rd_status(input string n, input logic [31:0] e);
        avs_chipselect = 1; avs_read = 1; avs_address = 12'hFFF;
        tick();
        avs_chipselect = 0; avs_read = 0;
        chk(n, avs_readdata, e);
    endtask

    initial begin
        tbl[0] = '{1, 12'hFFF, 32'h0,        32'h0000_0004};
        tbl[1] = '{0, 12'h001, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1, 12'hFFF, 32'h0,        32'h0000_0100};
        tbl[3] = '{1, 12'h123, 32'h0,        32'h0};
        tbl[4] = '{0, 12'hFFF, 32'h2,        32'h0};
        tbl[5] = '{1, 12'hFFF, 32'h0,        32'h0000_0102};
        tbl[6] = '{0, 12'hFFF, 32'h0,        32'h0};
        tbl[7] = '{1, 12'hFFF, 32'h0,        32'h0000_0100};
        tbl[8] = '{0, 12'hFFF, 32'h2,        32'h0};
        tbl[9] = '{1, 12'hFFF, 32'h0,        32'h0000_0102};

        repeat (3) tick();
        chk("reset_ppu_write", ppu_write, 0);
        chk("reset_ppu_cs", ppu_chipselect, 0);
        chk("reset_irq", irq, 0);
        chk("reset_readdata", avs_readdata, 0);
        chk("reset_waitreq", avs_waitrequest, 0);
        reset = 0;
        tick();

        for (int i = 0; i < 10; i++) begin
            avs_chipselect = 1; avs_write = !tbl[i].rd; avs_read = tbl[i].rd;
            avs_address = tbl[i].addr; avs_writedata = tbl[i].data;
            #1;
            if (!tbl[i].rd) chk($sformatf("vec%0d_waitreq", i), avs_waitrequest, tbl[i].exp);
            @(posedge clk); #1;
            avs_chipselect = 0; avs_write = 0; avs_read = 0;
            if (tbl[i].rd) chk($sformatf("vec%0d_readdata", i), avs_readdata, tbl[i].exp);
        end
        chk("no_drain_without_vblank", ga.size(), 0);

        // single entry drains two cycles after vblank rises
        vblank = 1;
        tick();
        chk("drain_lat_early", ppu_write, 0);
        tick();
        chk("drain_write", ppu_write, 1);
        chk("drain_cs", ppu_chipselect, 1);
        chk("drain_addr", ppu_address, 12'h001);
        chk("drain_data", ppu_write_data, 32'hDEADBEEF);
        chk("irq_on_rise", irq, 1);
        tick();
        chk("drain_one_pulse", ppu_write, 0);
        rd_status("status_after_drain", 32'h0000_0007);
        wr(12'hFFF, 32'h3);
        chk("irq_cleared", irq, 0);
        vblank = 0;
        tick();

        // fill to full, 65th write stalls until a slot frees during vblank
        ga.delete(); gd.delete();
        for (int i = 0; i < 64; i++) wr(12'(12'h100 + i), 32'hA000_0000 + i);
        rd_status("status_full", 32'h0000_400A);
        avs_chipselect = 1; avs_write = 1; avs_address = 12'h140; avs_writedata = 32'hA000_0040;
        #1;
        chk("waitreq_full", avs_waitrequest, 1);
        repeat (3) tick();
        chk("waitreq_held", avs_waitrequest, 1);
        vblank = 1;
        begin
            int n = 0;
            while (avs_waitrequest && n < 20) begin tick(); n++; end
            chk("waitreq_release", avs_waitrequest, 0);
        end
        tick();
        avs_chipselect = 0; avs_write = 0;
        for (int n = 0; n < 200 && ga.size() < 65; n++) tick();
        chk("full_drain_count", ga.size(), 65);
        for (int i = 0; i < 65 && i < ga.size(); i++) begin
            chk($sformatf("order_addr%0d", i), ga[i], 12'(12'h100 + i));
            chk($sformatf("order_data%0d", i), gd[i], 32'hA000_0000 + i);
        end
        vblank = 0;
        tick();
        wr(12'hFFF, 32'h3);

        // vblank drops after 10 pops; the rest waits for the next frame
        ga.delete(); gd.delete();
        for (int i = 0; i < 64; i++) wr(12'(12'h200 + i), 32'hB000_0000 + i);
        vblank = 1;
        tick();
        repeat (10) tick();
        vblank = 0;
        repeat (5) tick();
        chk("partial_pulses", ga.size(), 10);
        rd_status("status_partial", 32'h0000_3603);
        vblank = 1;
        for (int n = 0; n < 200 && ga.size() < 64; n++) tick();
        chk("partial_total", ga.size(), 64);
        for (int i = 0; i < 64 && i < ga.size(); i++)
            chk($sformatf("partial_addr%0d", i), ga[i], 12'(12'h200 + i));
        vblank = 0;
        tick();

        // IRQ set wins over a clear in the same cycle
        wr(12'hFFF, 32'h3);
        chk("irq_clr_d", irq, 0);
        vblank = 1;
        tick();
        chk("irq_frame1", irq, 1);
        vblank = 0;
        repeat (2) tick();
        wr(12'hFFF, 32'h3);
        chk("irq_clr_between", irq, 0);
        vblank = 1;
        avs_chipselect = 1; avs_write = 1; avs_address = 12'hFFF; avs_writedata = 32'h1;
        tick();
        avs_chipselect = 0; avs_write = 0;
        chk("irq_set_wins", irq, 1);
        rd_status("status_en_off_pending", 32'h0000_0005);
        wr(12'hFFF, 32'h1);
        chk("irq_clr_final", irq, 0);
        vblank = 0;
        tick();

        // reset in the middle of a drain
        wr(12'hFFF, 32'h2);
        for (int i = 0; i < 20; i++) wr(12'(12'h300 + i), 32'hC000_0000 + i);
        vblank = 1;
        repeat (3) tick();
        chk("pre_reset_irq", irq, 1);
        reset = 1; vblank = 0;
        tick();
        chk("rst_mid_ppu_write", ppu_write, 0);
        chk("rst_mid_ppu_addr", ppu_address, 0);
        chk("rst_mid_irq", irq, 0);
        reset = 0;
        rd_status("status_after_reset", 32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
